res_nibble_serial: RTL and testbench
====================================

Name: res_nibble_serial

Overview:
- Multi-cycle subtractor: d = a - b over NIBBLES*4 bits.
- Processes one nibble per clock through a single 4-bit adder slice, computing a + ~b + carry, least-significant nibble first.
- Area-lean counterpart to the ripple nibble adder. Sits in the CPU datapath as the SUB/CMP engine and reports borrow, zero and signed overflow.

Parameters:
- NIBBLES, 4: operand width in nibbles; W = 4*NIBBLES bits. Legal range 2..8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while busy=0
- a  input  W  minuend; captured on the accepting edge
- b  input  W  subtrahend; captured on the accepting edge
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse; result valid
- d  output  W  difference; held stable from done until the next accept
- bout  output  1  unsigned borrow (a < b)
- z  output  1  d == 0
- v  output  1  signed (two's complement) overflow

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, d=0, bout=0, z=0, v=0; nibble index=0; carry=1.
- States: IDLE, RUN, DONE.
  - IDLE/DONE -> RUN on start=1.
  - RUN -> DONE after nibble NIBBLES-1.
  - DONE -> IDLE when start=0.
- Accept edge (start=1 and busy=0):
  - Capture a and b into internal registers; index=0; carry=1 (two's-complement +1).
  - busy=1 and done=0 after this edge.
- RUN, each edge:
  - Slice computes {cout, s} = a[i] + ~b[i] + carry, where i = index.
  - s is written to d nibble i; carry=cout; index increments.
  - Nibble i is processed on accept edge + (i+1).
- Last nibble (index = NIBBLES-1), on the same edge:
  - bout = ~cout.
  - z = (all written nibbles, including this s, are zero).
  - v = (a_msb != b_msb) && (s_msb != a_msb).
  - busy=0, done=1.
- Latency: done is high in the cycle following edge accept+NIBBLES; fixed, data-independent.
- done lasts exactly one cycle. It is also cleared by an accept in the DONE state (back-to-back operation).
- Result stability:
  - d, bout, z, v hold until the next accept.
  - During RUN, d is partially updated and not valid; z, bout and v keep their previous values until the final edge.
- start while busy=1: ignored. Operands are not re-captured and no error is flagged.
- a and b changing after the accept edge: no effect (registered copies are used).
- Reset mid-RUN: immediate return to reset values; the partial result is discarded.
- Wrap-around: the result is modulo 2^W. Borrow and overflow are reported only via bout and v.

Decomposition:
- Shared package/include:
  - State encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Nibble width constant NIB_W=4.
  - Index width function clog2(NIBBLES).
- Sub-module: instantiate the existing sum_nibble as the slice.
  - Connections: x=a nibble, y=~b nibble, c0=carry register, s to d nibble, c4 to cout.
  - No new arithmetic module is written.
- Operand registers may be implemented as right shifters (nibble 0 always at the bottom) to avoid an index mux. Either form is acceptable if timing is met.

Test Plan (NIBBLES=4):
1. a=0x1234, b=0x0234, start 1 cycle -> busy high for 4 cycles; done at accept+4 edges; d=0x1000, bout=0, z=0, v=0.
2. a=0x0005, b=0x0007 -> d=0xFFFE, bout=1, z=0, v=0.
3. a=0x8000, b=0x0001 -> d=0x7FFF, bout=0, v=1; then a=0x7FFF, b=0xFFFF -> d=0x8000, bout=1, v=1.
4. a=0xABCD, b=0xABCD -> d=0x0000, z=1, bout=0, v=0; then a=0, b=0 -> z=1.
5. Start during RUN with a=0xFFFF, b=0x0001 -> ignored; the first operation's result is unchanged. Then rst_n low at accept+2 -> busy=0, done=0, d=0 immediately; no done pulse afterwards.
6. Back-to-back: hold start=1 with new operands (0x0010-0x0001) in the done cycle -> accepted; done drops; second done after 4 more edges with d=0x000F.

Source files
------------

// File: rtl/res_nibble_serial_pkg.sv
// Shared definitions for the nibble-serial subtractor.
//   - FSM state encoding (IDLE / RUN / DONE)
//   - nibble width constant
//   - clog2 helper for sizing the nibble index
package res_nibble_serial_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  // Ceiling log2, minimum 1 so a 1-bit index still exists for small operands.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/sum_nibble.sv
// 4-bit adder slice: {c4_o, s_o} = x_i + y_i + c0_i.
// Ports:
//   x_i, y_i : nibble operands
//   c0_i     : carry in
//   s_o      : nibble sum
//   c4_o     : carry out
module sum_nibble
  import res_nibble_serial_pkg::*;
(
  input  logic [NIB_W-1:0] x_i,
  input  logic [NIB_W-1:0] y_i,
  input  logic             c0_i,
  output logic [NIB_W-1:0] s_o,
  output logic             c4_o
);

  logic [NIB_W:0] sum;

  assign sum  = {1'b0, x_i} + {1'b0, y_i} + {{NIB_W{1'b0}}, c0_i};
  assign s_o  = sum[NIB_W-1:0];
  assign c4_o = sum[NIB_W];

endmodule

// File: rtl/res_nibble_serial.sv
// Multi-cycle subtractor d = a - b, one nibble per clock through a single
// 4-bit slice computing a + ~b + carry, LSB nibble first.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start_i    : request, sampled only while not busy
//   a_i, b_i   : minuend / subtrahend, captured on the accepting edge
//   busy_o     : nibbles in flight
//   done_o     : one-cycle pulse, result valid
//   d_o        : difference, stable from done until the next accept
//   bout_o     : unsigned borrow (a < b)
//   z_o        : difference is zero
//   v_o        : signed overflow
module res_nibble_serial
  import res_nibble_serial_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [NIB_W*NIBBLES-1:0] a_i,
  input  logic [NIB_W*NIBBLES-1:0] b_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [NIB_W*NIBBLES-1:0] d_o,
  output logic                     bout_o,
  output logic                     z_o,
  output logic                     v_o
);

  localparam int unsigned W  = NIB_W * NIBBLES;
  localparam int unsigned IW = clog2(NIBBLES);
  localparam logic [IW-1:0] LastIdx = IW'(NIBBLES - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;   // right shifter: current nibble always at the bottom
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  d_q, d_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          zacc_q, zacc_d; // all nibbles written so far are zero
  logic          bout_q, bout_d;
  logic          z_q, z_d;
  logic          v_q, v_d;

  logic [NIB_W-1:0] s;
  logic             cout;
  logic             accept;
  logic             last;

  sum_nibble u_slice (
    .x_i  (a_q[NIB_W-1:0]),
    .y_i  (~b_q[NIB_W-1:0]),
    .c0_i (carry_q),
    .s_o  (s),
    .c4_o (cout)
  );

  assign accept = start_i && (state_q != StRun);
  assign last   = (idx_q == LastIdx);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    bout_d  = bout_q;
    z_d     = z_q;
    v_d     = v_q;

    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = start_i ? StRun : StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      a_d     = a_i;
      b_d     = b_i;
      idx_d   = '0;
      carry_d = 1'b1; // two's-complement +1
      zacc_d  = 1'b1;
    end else if (state_q == StRun) begin
      a_d     = a_q >> NIB_W;
      b_d     = b_q >> NIB_W;
      carry_d = cout;
      zacc_d  = zacc_q && (s == '0);
      d_d[idx_q*NIB_W +: NIB_W] = s;
      if (last) begin
        idx_d  = '0;
        bout_d = ~cout;
        z_d    = zacc_q && (s == '0);
        // After shifting, bit NIB_W-1 of the operand registers holds the original MSBs.
        v_d    = (a_q[NIB_W-1] != b_q[NIB_W-1]) && (s[NIB_W-1] != a_q[NIB_W-1]);
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b1;
      zacc_q  <= 1'b1;
      bout_q  <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      bout_q  <= bout_d;
      z_q     <= z_d;
      v_q     <= v_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign d_o    = d_q;
  assign bout_o = bout_q;
  assign z_o    = z_q;
  assign v_o    = v_q;

endmodule

// File: tb/tb_res_nibble_serial.sv
// Directed bench for res_nibble_serial with NIBBLES=4.
module tb_res_nibble_serial;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] d_o;
  logic        bout_o;
  logic        z_o;
  logic        v_o;

  int tests;
  int fails;
  int busy_cnt;
  int lat;

  res_nibble_serial #(.NIBBLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .d_o     (d_o),
    .bout_o  (bout_o),
    .z_o     (z_o),
    .v_o     (v_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge, scramble operands afterwards, then wait for done.
  // lat = edges after the accept edge until done is observed (0 = timeout).
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    start_i = 1'b1;
    a_i     = av;
    b_i     = bv;
    @(posedge clk);
    #1;
    start_i  = 1'b0;
    a_i      = 16'hDEAD;
    b_i      = 16'hBEEF;
    busy_cnt = busy_o ? 1 : 0;
    lat      = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (busy_o) busy_cnt++;
      if (done_o) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy_o, done_o, d_o, bout_o, z_o, v_o} !== 21'd0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b d=%h bout=%b z=%b v=%b, need all 0",
               busy_o, done_o, d_o, bout_o, z_o, v_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op(16'h1234, 16'h0234);
    tests++;
    if (lat !== 4 || busy_cnt !== 4) begin
      fails++;
      $display("FAIL basic_timing: lat=%0d busy_cycles=%0d, need 4 and 4", lat, busy_cnt);
    end
    tests++;
    if ({d_o, bout_o, z_o, v_o} !== {16'h1000, 3'b000}) begin
      fails++;
      $display("FAIL basic_result: d=%h bout=%b z=%b v=%b, need 1000 0 0 0", d_o, bout_o, z_o, v_o);
    end
    @(posedge clk);
    #1;
    tests++;
    if (done_o !== 1'b0 || d_o !== 16'h1000) begin
      fails++;
      $display("FAIL done_pulse: done=%b d=%h, need 0 and 1000 (held)", done_o, d_o);
    end
  endtask

  task automatic test_borrow();
    run_op(16'h0005, 16'h0007);
    tests++;
    if (lat !== 4 || {d_o, bout_o, z_o, v_o} !== {16'hFFFE, 3'b100}) begin
      fails++;
      $display("FAIL borrow: lat=%0d d=%h bout=%b z=%b v=%b, need 4 FFFE 1 0 0",
               lat, d_o, bout_o, z_o, v_o);
    end
  endtask

  task automatic test_overflow();
    run_op(16'h8000, 16'h0001);
    tests++;
    if ({d_o, bout_o, z_o, v_o} !== {16'h7FFF, 3'b001}) begin
      fails++;
      $display("FAIL ovf_neg: d=%h bout=%b z=%b v=%b, need 7FFF 0 0 1", d_o, bout_o, z_o, v_o);
    end
    run_op(16'h7FFF, 16'hFFFF);
    tests++;
    if ({d_o, bout_o, z_o, v_o} !== {16'h8000, 3'b101}) begin
      fails++;
      $display("FAIL ovf_pos: d=%h bout=%b z=%b v=%b, need 8000 1 0 1", d_o, bout_o, z_o, v_o);
    end
  endtask

  task automatic test_zero();
    run_op(16'hABCD, 16'hABCD);
    tests++;
    if ({d_o, bout_o, z_o, v_o} !== {16'h0000, 3'b010}) begin
      fails++;
      $display("FAIL zero_eq: d=%h bout=%b z=%b v=%b, need 0000 0 1 0", d_o, bout_o, z_o, v_o);
    end
    // Flags must hold their old values while a new run is in progress.
    @(negedge clk);
    start_i = 1'b1;
    a_i     = 16'h0100;
    b_i     = 16'h0000;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (busy_o !== 1'b1 || z_o !== 1'b1) begin
      fails++;
      $display("FAIL flag_hold: busy=%b z=%b, need 1 and 1", busy_o, z_o);
    end
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (d_o !== 16'h0100 || z_o !== 1'b0) begin
      fails++;
      $display("FAIL upper_nonzero: d=%h z=%b, need 0100 and 0", d_o, z_o);
    end
    run_op(16'h0000, 16'h0000);
    tests++;
    if ({d_o, bout_o, z_o, v_o} !== {16'h0000, 3'b010}) begin
      fails++;
      $display("FAIL zero_0: d=%h bout=%b z=%b v=%b, need 0000 0 1 0", d_o, bout_o, z_o, v_o);
    end
  endtask

  task automatic test_ignore_and_reset();
    bit seen;
    // Accept 9-3, then try to start FFFF-1 while busy.
    @(negedge clk);
    start_i = 1'b1;
    a_i     = 16'h0009;
    b_i     = 16'h0003;
    @(negedge clk);
    a_i = 16'hFFFF;
    b_i = 16'h0001;
    @(negedge clk);
    start_i = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        lat = 1;
        break;
      end
    end
    tests++;
    if (lat !== 1 || d_o !== 16'h0006 || bout_o !== 1'b0) begin
      fails++;
      $display("FAIL ignore_busy: seen_done=%0d d=%h bout=%b, need 1 0006 0", lat, d_o, bout_o);
    end
    @(posedge clk);
    #1;
    tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      fails++;
      $display("FAIL no_second_op: busy=%b done=%b, need 0 and 0", busy_o, done_o);
    end
    // Reset two edges after accept.
    @(negedge clk);
    start_i = 1'b1;
    a_i     = 16'h5555;
    b_i     = 16'h1111;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy_o, done_o, d_o, bout_o, z_o, v_o} !== 21'd0) begin
      fails++;
      $display("FAIL reset_mid_run: busy=%b done=%b d=%h bout=%b z=%b v=%b, need all 0",
               busy_o, done_o, d_o, bout_o, z_o, v_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done_o || busy_o) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_quiet: activity=%b, need 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    run_op(16'h0005, 16'h0003);
    tests++;
    if (lat !== 4 || d_o !== 16'h0002) begin
      fails++;
      $display("FAIL b2b_first: lat=%0d d=%h, need 4 and 0002", lat, d_o);
    end
    // Still in the done cycle: request the next operation.
    start_i = 1'b1;
    a_i     = 16'h0010;
    b_i     = 16'h0001;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept: done=%b busy=%b, need 0 and 1", done_o, busy_o);
    end
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        lat = i;
        break;
      end
    end
    tests++;
    if (lat !== 4 || {d_o, bout_o, z_o, v_o} !== {16'h000F, 3'b000}) begin
      fails++;
      $display("FAIL b2b_second: lat=%0d d=%h bout=%b z=%b v=%b, need 4 000F 0 0 0",
               lat, d_o, bout_o, z_o, v_o);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_zero();
    test_ignore_and_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
